fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Single-outstanding-request instruction fetch stage. It reads one 16-bit
//   word from instruction memory, presents it to decode with a valid/ready
//   handshake, and then moves to the next sequential address. A redirect
//   restarts fetch at a new address. Fetching a HALT_OP word stops the unit
//   until a redirect or reset.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst_n        in   synchronous active-low reset (outranks redirect)
//   imem_req     out  memory read request, high while in FETCH
//   imem_addr    out  [PC_W] address being requested (fetch_pc)
//   imem_ack     in   memory data valid this cycle
//   imem_data    in   [16] instruction word from memory
//   inst         out  [16] instruction presented to decode
//   inst_valid   out  inst holds a valid instruction
//   inst_ready   in   decode accepts inst this cycle
//   inst_pc      out  [PC_W] address inst was fetched from
//   redirect     in   restart fetch at redirect_pc
//   redirect_pc  in   [PC_W] restart address
//   halted       out  a HALT_OP word was fetched; fetching stopped
// ----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned          PC_W     = 8,
  parameter logic [PC_W-1:0]      RESET_PC = '0,
  parameter logic [3:0]           HALT_OP  = 4'hC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [15:0]     inst,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [PC_W-1:0] inst_pc,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            halted
);

  localparam int unsigned INST_W = 16;
  localparam int unsigned OP_W   = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e              state_q,      state_d;
  logic [PC_W-1:0]     fetch_pc_q,   fetch_pc_d;
  logic [INST_W-1:0]   inst_q,       inst_d;
  logic [PC_W-1:0]     inst_pc_q,    inst_pc_d;
  logic                inst_valid_q, inst_valid_d;
  logic                halted_q,     halted_d;

  logic [OP_W-1:0]     ack_op;

  assign ack_op = imem_data[INST_W-1:INST_W-OP_W];

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      fetch_pc_q   <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= RESET_PC;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      halted_q     <= halted_d;
    end
  end

  // Next-state and next-register logic; redirect outranks ack and ready.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    halted_d     = halted_q;

    if (redirect) begin
      state_d      = FETCH;
      fetch_pc_d   = redirect_pc;
      inst_valid_d = 1'b0;
      halted_d     = 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ack) begin
            if (ack_op == HALT_OP) begin
              // Halt word is consumed, never shown to decode; pc stays put.
              state_d  = HALT;
              halted_d = 1'b1;
            end else begin
              state_d      = HOLD;
              inst_d       = imem_data;
              inst_pc_d    = fetch_pc_q;
              inst_valid_d = 1'b1;
              // Natural wrap at 2^PC_W.
              fetch_pc_d   = PC_W'(fetch_pc_q + PC_W'(1));
            end
          end
        end
        HOLD: begin
          if (inst_ready) begin
            state_d      = FETCH;
            inst_valid_d = 1'b0;
          end
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  // Request is a decode of the state register, masked while reset is held so
  // it is low during reset and high in the first cycle after release.
  assign imem_req   = rst_n && (state_q == FETCH);
  assign imem_addr  = fetch_pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. Inputs are driven and outputs sampled on
//   the falling edge; every expected value is written out by hand.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [7:0]  inst_pc;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        halted;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_pc     (inst_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one full clock; returns just after the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Complete a one-cycle fetch of word w, then let decode take it.
  task automatic quick_fetch(input logic [15:0] w);
    imem_ack  = 1'b1;
    imem_data = w;
    inst_ready = 1'b1;
    step();
    imem_ack = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_data = '0; inst_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    @(negedge clk);
    step();
    step();

    // Reset state
    check("rst_req",    32'(imem_req),   32'h0);
    check("rst_valid",  32'(inst_valid), 32'h0);
    check("rst_halted", 32'(halted),     32'h0);
    check("rst_inst",   32'(inst),       32'h0);
    check("rst_ipc",    32'(inst_pc),    32'h0);
    check("rst_addr",   32'(imem_addr),  32'h0);

    rst_n = 1'b1;
    #1;
    check("rel_req",  32'(imem_req),  32'h1);
    check("rel_addr", 32'(imem_addr), 32'h0);

    // Two back-to-back single-cycle fetches
    imem_ack = 1'b1; imem_data = 16'hF10A; inst_ready = 1'b1;
    step();
    check("a0_valid", 32'(inst_valid), 32'h1);
    check("a0_inst",  32'(inst),       32'hF10A);
    check("a0_ipc",   32'(inst_pc),    32'h0);
    check("a0_req",   32'(imem_req),   32'h0);
    imem_ack = 1'b0;
    step();
    check("a0_drop",  32'(inst_valid), 32'h0);
    check("a1_req",   32'(imem_req),   32'h1);
    check("a1_addr",  32'(imem_addr),  32'h1);
    imem_ack = 1'b1; imem_data = 16'hF202;
    step();
    check("a1_valid", 32'(inst_valid), 32'h1);
    check("a1_inst",  32'(inst),       32'hF202);
    check("a1_ipc",   32'(inst_pc),    32'h1);
    imem_ack = 1'b0;
    step();
    check("a1_drop",  32'(inst_valid), 32'h0);
    check("a2_addr",  32'(imem_addr),  32'h2);

    // Slow memory and slow decode
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("wait_addr", 32'(imem_addr), 32'h2);
      check("wait_req",  32'(imem_req),  32'h1);
      step();
    end
    imem_ack = 1'b1; imem_data = 16'h1234;
    step();
    // Stray acks while not requesting must not disturb the held instruction.
    imem_data = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      check("hold_valid", 32'(inst_valid), 32'h1);
      check("hold_inst",  32'(inst),       32'h1234);
      check("hold_ipc",   32'(inst_pc),    32'h2);
      check("hold_req",   32'(imem_req),   32'h0);
      step();
    end
    imem_ack = 1'b0; inst_ready = 1'b1;
    step();
    check("hold_done",  32'(inst_valid), 32'h0);
    check("a3_addr",    32'(imem_addr),  32'h3);

    // Redirect coinciding with ack at addr 5
    quick_fetch(16'h1111);
    quick_fetch(16'h2222);
    check("a5_addr", 32'(imem_addr), 32'h5);
    imem_ack = 1'b1; imem_data = 16'h3333; redirect = 1'b1; redirect_pc = 8'h40;
    step();
    check("rd_valid", 32'(inst_valid), 32'h0);
    check("rd_req",   32'(imem_req),   32'h1);
    check("rd_addr",  32'(imem_addr),  32'h40);
    redirect = 1'b0; imem_data = 16'h4444;
    step();
    check("rd_inst", 32'(inst),    32'h4444);
    check("rd_ipc",  32'(inst_pc), 32'h40);

    // Redirect while holding drops the held instruction
    inst_ready = 1'b0; imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 8'h80;
    step();
    check("rdh_valid", 32'(inst_valid), 32'h0);
    check("rdh_addr",  32'(imem_addr),  32'h80);
    check("rdh_req",   32'(imem_req),   32'h1);

    // Halt word at addr 3
    redirect_pc = 8'h03;
    step();
    redirect = 1'b0; imem_ack = 1'b1; imem_data = 16'hC000;
    step();
    check("h_halted", 32'(halted),     32'h1);
    check("h_valid",  32'(inst_valid), 32'h0);
    check("h_req",    32'(imem_req),   32'h0);
    check("h_addr",   32'(imem_addr),  32'h3);
    imem_data = 16'h5678; inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hs_halted", 32'(halted),     32'h1);
      check("hs_req",    32'(imem_req),   32'h0);
      check("hs_valid",  32'(inst_valid), 32'h0);
    end
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 8'h10;
    step();
    redirect = 1'b0;
    check("hx_halted", 32'(halted),    32'h0);
    check("hx_addr",   32'(imem_addr), 32'h10);
    check("hx_req",    32'(imem_req),  32'h1);

    // Wrap from FF to 00
    redirect = 1'b1; redirect_pc = 8'hFF;
    step();
    redirect = 1'b0; imem_ack = 1'b1; imem_data = 16'h5555;
    step();
    check("w_ipc",  32'(inst_pc), 32'hFF);
    check("w_inst", 32'(inst),    32'h5555);
    imem_ack = 1'b0;
    step();
    check("w_addr", 32'(imem_addr), 32'h00);

    // Reset during HOLD, with redirect and ack also asserted
    imem_ack = 1'b1; imem_data = 16'h6666; inst_ready = 1'b0;
    step();
    check("rh_valid0", 32'(inst_valid), 32'h1);
    rst_n = 1'b0; redirect = 1'b1; redirect_pc = 8'h20;
    step();
    check("rh_valid",  32'(inst_valid), 32'h0);
    check("rh_inst",   32'(inst),       32'h0);
    check("rh_ipc",    32'(inst_pc),    32'h0);
    check("rh_req",    32'(imem_req),   32'h0);
    check("rh_halted", 32'(halted),     32'h0);
    step();
    check("rh_addr_in", 32'(imem_addr), 32'h0);
    rst_n = 1'b1; redirect = 1'b0; imem_ack = 1'b0;
    #1;
    check("rh_req_out",  32'(imem_req),  32'h1);
    check("rh_addr_out", 32'(imem_addr), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
